// File: rtl/bsg_manycore_io_mux.sv
// Spreads the single host loader link across the enabled manycore top-row I/O ports.
// Host requests are dispatched round-robin under per-port credit limits; mesh traffic is merged round-robin.
module bsg_manycore_io_mux
  #(parameter int addr_width_p      = 16
  , parameter int data_width_p      = 32
  , parameter int x_cord_width_p    = 4
  , parameter int y_cord_width_p    = 4
  , parameter int num_io_p          = 4
  , parameter logic [num_io_p-1:0] io_en_mask_p = {num_io_p{1'b1}}
  , parameter int max_out_credits_p = 16
  , parameter int return_fifo_els_p = 16
  , localparam int fwd_pkt_width_lp  = 2 + addr_width_p + data_width_p + 2*(x_cord_width_p + y_cord_width_p)
  , localparam int rev_pkt_width_lp  = 2 + data_width_p + x_cord_width_p + y_cord_width_p
  , localparam int link_sif_width_lp = fwd_pkt_width_lp + rev_pkt_width_lp + 4
  , localparam int credit_width_lp   = $clog2(max_out_credits_p + 1))
  (input  logic                                        clk_i
  , input  logic                                       reset_i
  , input  logic [link_sif_width_lp-1:0]               host_link_sif_i
  , output logic [link_sif_width_lp-1:0]               host_link_sif_o
  , input  logic [num_io_p-1:0][link_sif_width_lp-1:0] io_link_sif_i
  , output logic [num_io_p-1:0][link_sif_width_lp-1:0] io_link_sif_o
  , output logic [num_io_p-1:0][credit_width_lp-1:0]   out_credits_o
  , output logic [15:0]                                stray_count_o
  , output logic                                       stray_err_o
  , output logic                                       idle_o
  );

  localparam int id_width_lp       = (num_io_p > 1) ? $clog2(num_io_p) : 1;
  localparam int fifo_ptr_width_lp = (return_fifo_els_p > 1) ? $clog2(return_fifo_els_p) : 1;
  localparam int fifo_cnt_width_lp = $clog2(return_fifo_els_p + 1);

  // First requester at or after ptr, wrapping; MSB of the result flags "found".
  function automatic logic [id_width_lp:0] rr_pick(input logic [num_io_p-1:0] req,
                                                   input logic [id_width_lp-1:0] ptr);
    logic [id_width_lp:0] res;
    int idx;
    res = '0;
    for (int i = num_io_p-1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % num_io_p;
      if (req[idx]) res = {1'b1, id_width_lp'(idx)};
    end
    return res;
  endfunction

  function automatic logic [id_width_lp-1:0] next_enabled(input logic [id_width_lp-1:0] w);
    logic [id_width_lp-1:0] res;
    int idx;
    res = w;
    for (int i = num_io_p; i >= 1; i--) begin
      idx = (int'(w) + i) % num_io_p;
      if (io_en_mask_p[idx]) res = id_width_lp'(idx);
    end
    return res;
  endfunction

  function automatic logic [id_width_lp-1:0] first_enabled();
    logic [id_width_lp-1:0] res;
    res = '0;
    for (int i = num_io_p-1; i >= 0; i--)
      if (io_en_mask_p[i]) res = id_width_lp'(i);
    return res;
  endfunction

  localparam logic [id_width_lp-1:0] first_en_lp = first_enabled();

  logic                        from_host_fwd_v, from_host_fwd_ready, from_host_rev_v, from_host_rev_ready;
  logic [fwd_pkt_width_lp-1:0] from_host_fwd_data;
  logic [rev_pkt_width_lp-1:0] from_host_rev_data;

  assign {from_host_fwd_v, from_host_fwd_data, from_host_fwd_ready,
          from_host_rev_v, from_host_rev_data, from_host_rev_ready} = host_link_sif_i;

  logic [num_io_p-1:0]         from_io_fwd_v, from_io_fwd_ready, from_io_rev_v, from_io_rev_ready;
  logic [fwd_pkt_width_lp-1:0] from_io_fwd_data [num_io_p];
  logic [rev_pkt_width_lp-1:0] from_io_rev_data [num_io_p];
  logic [num_io_p-1:0]         to_io_fwd_v, to_io_fwd_ready, to_io_rev_v, to_io_rev_ready;
  logic [num_io_p-1:0]         fwd_elig, cred_inc, cred_dec;
  logic [credit_width_lp-1:0]  credits_r [num_io_p];

  logic [id_width_lp-1:0] fwd_ptr_r, rev_ptr_r, mfwd_ptr_r;
  logic [id_width_lp:0]   fwd_pick, rev_pick, mfwd_pick;
  logic [id_width_lp-1:0] fwd_win, rev_win, mfwd_win, fifo_head;
  logic                   fwd_any, rev_any, mfwd_any;
  logic                   fwd_hs, rev_hs, mfwd_hs, fifo_pop, fifo_can_push, fifo_nonempty;
  logic                   to_host_fwd_v, to_host_fwd_ready, to_host_rev_v, to_host_rev_ready;

  // Host to mesh requests
  assign fwd_pick          = rr_pick(fwd_elig, fwd_ptr_r);
  assign fwd_any           = fwd_pick[id_width_lp];
  assign fwd_win           = fwd_pick[id_width_lp-1:0];
  assign to_host_fwd_ready = fwd_any & ~reset_i;
  assign fwd_hs            = from_host_fwd_v & to_host_fwd_ready;

  // Mesh to host responses
  assign rev_pick      = rr_pick(from_io_rev_v & io_en_mask_p, rev_ptr_r);
  assign rev_any       = rev_pick[id_width_lp];
  assign rev_win       = rev_pick[id_width_lp-1:0];
  assign to_host_rev_v = rev_any & ~reset_i;
  assign rev_hs        = to_host_rev_v & from_host_rev_ready;

  // Mesh to host requests; a push may reuse the slot freed by a same-cycle pop
  assign mfwd_pick     = rr_pick(from_io_fwd_v & io_en_mask_p, mfwd_ptr_r);
  assign mfwd_any      = mfwd_pick[id_width_lp];
  assign mfwd_win      = mfwd_pick[id_width_lp-1:0];
  assign to_host_fwd_v = mfwd_any & fifo_can_push & ~reset_i;
  assign mfwd_hs       = to_host_fwd_v & from_host_fwd_ready;

  // Host to mesh responses, steered in order to the requesting port
  assign to_host_rev_ready = fifo_nonempty & from_io_rev_ready[fifo_head] & ~reset_i;
  assign fifo_pop          = from_host_rev_v & to_host_rev_ready;

  assign host_link_sif_o = {to_host_fwd_v, from_io_fwd_data[mfwd_win], to_host_fwd_ready,
                            to_host_rev_v, from_io_rev_data[rev_win], to_host_rev_ready};

  genvar gi;
  generate
    for (gi = 0; gi < num_io_p; gi++) begin : g_port
      assign {from_io_fwd_v[gi], from_io_fwd_data[gi], from_io_fwd_ready[gi],
              from_io_rev_v[gi], from_io_rev_data[gi], from_io_rev_ready[gi]} = io_link_sif_i[gi];

      assign fwd_elig[gi] = io_en_mask_p[gi] & from_io_fwd_ready[gi]
                          & (credits_r[gi] < credit_width_lp'(max_out_credits_p));
      assign cred_inc[gi] = fwd_hs & (fwd_win == id_width_lp'(gi));
      assign cred_dec[gi] = rev_hs & (rev_win == id_width_lp'(gi));

      // Disabled ports swallow everything and never drive a valid
      assign to_io_fwd_v[gi]     = cred_inc[gi];
      assign to_io_rev_v[gi]     = fifo_pop & (fifo_head == id_width_lp'(gi)) & io_en_mask_p[gi];
      assign to_io_fwd_ready[gi] = io_en_mask_p[gi] ? (mfwd_hs & (mfwd_win == id_width_lp'(gi))) : 1'b1;
      assign to_io_rev_ready[gi] = io_en_mask_p[gi] ? cred_dec[gi] : 1'b1;

      assign io_link_sif_o[gi] = {to_io_fwd_v[gi], from_host_fwd_data, to_io_fwd_ready[gi],
                                  to_io_rev_v[gi], from_host_rev_data, to_io_rev_ready[gi]};

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
          credits_r[gi] <= '0;
        else if (cred_inc[gi] & ~cred_dec[gi])
          credits_r[gi] <= credits_r[gi] + credit_width_lp'(1);
        else if (cred_dec[gi] & ~cred_inc[gi] & (credits_r[gi] != '0))
          credits_r[gi] <= credits_r[gi] - credit_width_lp'(1);
      end

      assign out_credits_o[gi] = credits_r[gi];

      assert property (@(posedge clk_i) disable iff (reset_i)
                       !(cred_dec[gi] && !cred_inc[gi] && (credits_r[gi] == '0)));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fwd_ptr_r  <= first_en_lp;
      rev_ptr_r  <= first_en_lp;
      mfwd_ptr_r <= first_en_lp;
    end else begin
      if (fwd_hs)  fwd_ptr_r  <= next_enabled(fwd_win);
      if (rev_hs)  rev_ptr_r  <= next_enabled(rev_win);
      if (mfwd_hs) mfwd_ptr_r <= next_enabled(mfwd_win);
    end
  end

  logic [id_width_lp-1:0]       fifo_mem [return_fifo_els_p];
  logic [fifo_ptr_width_lp-1:0] fifo_wr_r, fifo_rd_r;
  logic [fifo_cnt_width_lp-1:0] fifo_cnt_r;

  function automatic logic [fifo_ptr_width_lp-1:0] fifo_ptr_inc(input logic [fifo_ptr_width_lp-1:0] p);
    return (p == fifo_ptr_width_lp'(return_fifo_els_p - 1)) ? '0 : p + fifo_ptr_width_lp'(1);
  endfunction

  assign fifo_nonempty = (fifo_cnt_r != '0);
  assign fifo_can_push = (fifo_cnt_r != fifo_cnt_width_lp'(return_fifo_els_p)) | fifo_pop;
  assign fifo_head     = fifo_mem[fifo_rd_r];

  always_ff @(posedge clk_i) begin
    if (mfwd_hs) fifo_mem[fifo_wr_r] <= mfwd_win;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fifo_wr_r  <= '0;
      fifo_rd_r  <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (mfwd_hs)  fifo_wr_r <= fifo_ptr_inc(fifo_wr_r);
      if (fifo_pop) fifo_rd_r <= fifo_ptr_inc(fifo_rd_r);
      if (mfwd_hs & ~fifo_pop)      fifo_cnt_r <= fifo_cnt_r + fifo_cnt_width_lp'(1);
      else if (fifo_pop & ~mfwd_hs) fifo_cnt_r <= fifo_cnt_r - fifo_cnt_width_lp'(1);
    end
  end

  logic [num_io_p-1:0] stray_hits;
  logic [16:0]         stray_sum;
  logic [15:0]         stray_count_r;
  logic                stray_err_r;

  assign stray_hits = from_io_fwd_v & ~io_en_mask_p;
  assign stray_sum  = {1'b0, stray_count_r} + 17'($countones(stray_hits));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stray_count_r <= '0;
      stray_err_r   <= 1'b0;
    end else begin
      stray_count_r <= stray_sum[16] ? 16'hFFFF : stray_sum[15:0];
      stray_err_r   <= stray_err_r | (|stray_hits);
    end
  end

  assign stray_count_o = stray_count_r;
  assign stray_err_o   = stray_err_r;

  always_comb begin
    idle_o = ~fifo_nonempty;
    for (int i = 0; i < num_io_p; i++)
      if (credits_r[i] != '0) idle_o = 1'b0;
  end

endmodule

// File: tb/tb_bsg_manycore_io_mux.sv
// Randomized bench for bsg_manycore_io_mux against a queue/array reference model,
// including an asynchronous reset asserted in the middle of traffic.
module tb_bsg_manycore_io_mux;

  localparam int A = 4, D = 8, X = 2, Y = 2;
  localparam int N = 4;
  localparam logic [N-1:0] MASK = 4'b1011;
  localparam int MAXC  = 3;
  localparam int DEPTH = 4;
  localparam int FW = 2 + A + D + 2*(X + Y);
  localparam int RW = 2 + D + X + Y;
  localparam int LW = FW + RW + 4;
  localparam int CW = $clog2(MAXC + 1);
  localparam int RR_B = 0, RD_L = 1, RV_B = RW + 1, FR_B = RW + 2, FD_L = RW + 3, FV_B = RW + FW + 3;
  localparam int CYCLES = 3000;

  logic                   clk_i = 1'b0;
  logic                   reset_i;
  logic [LW-1:0]          host_link_sif_i, host_link_sif_o;
  logic [N-1:0][LW-1:0]   io_link_sif_i, io_link_sif_o;
  logic [N-1:0][CW-1:0]   out_credits_o;
  logic [15:0]            stray_count_o;
  logic                   stray_err_o, idle_o;

  bsg_manycore_io_mux #(
    .addr_width_p(A), .data_width_p(D), .x_cord_width_p(X), .y_cord_width_p(Y),
    .num_io_p(N), .io_en_mask_p(MASK), .max_out_credits_p(MAXC), .return_fifo_els_p(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .host_link_sif_i(host_link_sif_i), .host_link_sif_o(host_link_sif_o),
    .io_link_sif_i(io_link_sif_i), .io_link_sif_o(io_link_sif_o),
    .out_credits_o(out_credits_o), .stray_count_o(stray_count_o),
    .stray_err_o(stray_err_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus for the current cycle
  logic          h_fv, h_fr, h_rv, h_rr;
  logic [FW-1:0] h_fdata;
  logic [RW-1:0] h_rdata;
  logic [N-1:0]  p_fv, p_fr, p_rv, p_rr;
  logic [FW-1:0] p_fdata [N];
  logic [RW-1:0] p_rdata [N];

  // reference model state
  int fptr, rptr, mptr;
  int cred [N];
  int ret_q [$];
  int stray;
  bit err;

  function automatic int first_en();
    for (int k = 0; k < N; k++) if (MASK[k]) return k;
    return 0;
  endfunction

  function automatic int next_en(input int w);
    for (int k = 1; k <= N; k++) if (MASK[(w + k) % N]) return (w + k) % N;
    return w;
  endfunction

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    fptr = first_en(); rptr = first_en(); mptr = first_en();
    for (int p = 0; p < N; p++) cred[p] = 0;
    ret_q.delete();
    stray = 0; err = 0;
  endtask

  task automatic apply();
    host_link_sif_i = {h_fv, h_fdata, h_fr, h_rv, h_rdata, h_rr};
    for (int p = 0; p < N; p++)
      io_link_sif_i[p] = {p_fv[p], p_fdata[p], p_fr[p], p_rv[p], p_rdata[p], p_rr[p]};
  endtask

  task automatic drive_idle();
    h_fv = 0; h_fr = 0; h_rv = 0; h_rr = 0; h_fdata = '0; h_rdata = '0;
    p_fv = '0; p_fr = '0; p_rv = '0; p_rr = '0;
    for (int p = 0; p < N; p++) begin p_fdata[p] = '0; p_rdata[p] = '0; end
    apply();
  endtask

  task automatic drive_random(input int cyc);
    bit drain;
    drain   = ((cyc / 50) % 2) == 1;
    h_fv    = $urandom_range(0, 99) < 70;
    h_fr    = $urandom_range(0, 99) < 60;
    h_rv    = $urandom_range(0, 99) < (drain ? 80 : 10);
    h_rr    = $urandom_range(0, 99) < 70;
    h_fdata = FW'($urandom);
    h_rdata = RW'($urandom);
    for (int p = 0; p < N; p++) begin
      p_fv[p]    = $urandom_range(0, 99) < (MASK[p] ? 40 : 5);
      p_fr[p]    = $urandom_range(0, 99) < 70;
      p_rv[p]    = (cred[p] > 0) && ($urandom_range(0, 99) < (drain ? 20 : 50));
      p_rr[p]    = $urandom_range(0, 99) < 70;
      p_fdata[p] = FW'($urandom);
      p_rdata[p] = RW'($urandom);
    end
    apply();
  endtask

  task automatic step_check();
    logic [N-1:0] elig, rreq, mreq;
    int  fw, rw, mw, head;
    bit  nonempty, pop, can_push, hf, hr, hm, idle_exp;
    for (int p = 0; p < N; p++) begin
      elig[p] = MASK[p] && p_fr[p] && (cred[p] < MAXC);
      rreq[p] = MASK[p] && p_rv[p];
      mreq[p] = MASK[p] && p_fv[p];
    end
    fw = pick(elig, fptr);
    rw = pick(rreq, rptr);
    mw = pick(mreq, mptr);
    nonempty = ret_q.size() > 0;
    head     = nonempty ? ret_q[0] : 0;
    pop      = h_rv && nonempty && p_rr[head];
    can_push = (ret_q.size() < DEPTH) || pop;
    hf = h_fv && (fw >= 0);
    hr = (rw >= 0) && h_rr;
    hm = (mw >= 0) && can_push && h_fr;

    check("host_fwd_ready", host_link_sif_o[FR_B], fw >= 0);
    check("host_fwd_v", host_link_sif_o[FV_B], (mw >= 0) && can_push);
    if ((mw >= 0) && can_push) check("host_fwd_data", host_link_sif_o[FD_L +: FW], p_fdata[mw]);
    check("host_rev_v", host_link_sif_o[RV_B], rw >= 0);
    if (rw >= 0) check("host_rev_data", host_link_sif_o[RD_L +: RW], p_rdata[rw]);
    check("host_rev_ready", host_link_sif_o[RR_B], nonempty && p_rr[head]);
    for (int p = 0; p < N; p++) begin
      check($sformatf("io%0d_fwd_v", p), io_link_sif_o[p][FV_B], hf && (fw == p));
      if (hf && (fw == p)) check($sformatf("io%0d_fwd_data", p), io_link_sif_o[p][FD_L +: FW], h_fdata);
      check($sformatf("io%0d_fwd_ready", p), io_link_sif_o[p][FR_B], MASK[p] ? (hm && (mw == p)) : 1'b1);
      check($sformatf("io%0d_rev_v", p), io_link_sif_o[p][RV_B], pop && (head == p));
      if (pop && (head == p)) check($sformatf("io%0d_rev_data", p), io_link_sif_o[p][RD_L +: RW], h_rdata);
      check($sformatf("io%0d_rev_ready", p), io_link_sif_o[p][RR_B], MASK[p] ? (hr && (rw == p)) : 1'b1);
      check($sformatf("credits%0d", p), out_credits_o[p], cred[p]);
    end
    idle_exp = ret_q.size() == 0;
    for (int p = 0; p < N; p++) if (cred[p] != 0) idle_exp = 0;
    check("stray_count", stray_count_o, stray);
    check("stray_err", stray_err_o, err);
    check("idle", idle_o, idle_exp);

    if (hf) begin cred[fw]++; fptr = next_en(fw); end
    if (hr) begin cred[rw]--; rptr = next_en(rw); end
    if (pop) void'(ret_q.pop_front());
    if (hm) begin ret_q.push_back(mw); mptr = next_en(mw); end
    for (int p = 0; p < N; p++)
      if (!MASK[p] && p_fv[p]) begin
        stray = (stray < 65535) ? stray + 1 : 65535;
        err = 1;
      end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_idle"}, idle_o, 1'b1);
    check({tag, "_stray_count"}, stray_count_o, 16'd0);
    check({tag, "_stray_err"}, stray_err_o, 1'b0);
    check({tag, "_host_fwd_v"}, host_link_sif_o[FV_B], 1'b0);
    check({tag, "_host_rev_v"}, host_link_sif_o[RV_B], 1'b0);
    for (int p = 0; p < N; p++) begin
      check($sformatf("%s_credits%0d", tag, p), out_credits_o[p], 0);
      check($sformatf("%s_io%0d_fwd_v", tag, p), io_link_sif_o[p][FV_B], 1'b0);
      check($sformatf("%s_io%0d_rev_v", tag, p), io_link_sif_o[p][RV_B], 1'b0);
      if (!MASK[p]) begin
        check($sformatf("%s_io%0d_fwd_ready", tag, p), io_link_sif_o[p][FR_B], 1'b1);
        check($sformatf("%s_io%0d_rev_ready", tag, p), io_link_sif_o[p][RR_B], 1'b1);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check_reset("reset");

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk_i);
      reset_i = 1'b0;
      drive_random(cyc);
      #1;
      step_check();
      if (cyc == CYCLES / 2) begin
        // assert reset between edges with traffic still driven
        #2;
        reset_i = 1'b1;
        #1;
        check_reset("midreset");
        model_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
